// File: rtl/vector_engine_pkg.sv
// Shared definitions for the vector engine: op codes, FSM states and the lane-slice helper.
package vector_engine_pkg;

   typedef enum logic [1:0] {
      OP_VLOAD  = 2'b00,
      OP_VSTORE = 2'b01,
      OP_VADD   = 2'b10,
      OP_VADDS  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_LWAIT = 3'd2,
      ST_STORE = 3'd3,
      ST_ADD   = 3'd4,
      ST_WB    = 3'd5,
      ST_DONE  = 3'd6
   } state_e;

   // Lane 0 is the most significant lane of a packed vector.
   function automatic int lane_lsb(input int lanes, input int dw, input int lane);
      return (lanes - 1 - lane) * dw;
   endfunction

endpackage

// File: rtl/vector_regfile.sv
// Vector register file: NVREG packed vectors, one write port, two read ports plus a debug read.
module vector_regfile
   import vector_engine_pkg::*;
#(
   parameter int LANES = 4,
   parameter int DW    = 8,
   parameter int NVREG = 4,
   parameter int VRW   = 2
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  we,
   input  logic [VRW-1:0]        waddr,
   input  logic [LANES*DW-1:0]   wdata,
   input  logic [VRW-1:0]        ra_addr,
   output logic [LANES*DW-1:0]   ra_data,
   input  logic [VRW-1:0]        rb_addr,
   output logic [LANES*DW-1:0]   rb_data,
   input  logic [VRW-1:0]        dbg_sel,
   output logic [LANES*DW-1:0]   dbg_data
);

   logic [LANES*DW-1:0] vrf_r [NVREG];

   // Storage update: asynchronous clear, single write port
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NVREG; i++) begin
            vrf_r[i] <= '0;
         end
      end else if (we) begin
         vrf_r[waddr] <= wdata;
      end
   end

   assign ra_data  = vrf_r[ra_addr];
   assign rb_data  = vrf_r[rb_addr];
   assign dbg_data = vrf_r[dbg_sel];

endmodule

// File: rtl/vector_engine.sv
// Vector engine top: VLOAD/VSTORE over a synchronous memory port and lane-wise VADD.
// Define VECTOR_ENGINE_SAT_EN to enable op 11 (VADDS, saturating add); otherwise op 11 reports err.
module vector_engine
   import vector_engine_pkg::*;
#(
   parameter int LANES = 4,
   parameter int DW    = 8,
   parameter int AW    = 8,
   parameter int NVREG = 4,
   localparam int VRW  = (NVREG > 1) ? $clog2(NVREG) : 1
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [VRW-1:0]        vd,
   input  logic [VRW-1:0]        vs,
   input  logic [AW-1:0]         base,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [AW-1:0]         mem_addr,
   output logic [DW-1:0]         mem_wdata,
   output logic                  mem_re,
   output logic                  mem_we,
   input  logic [DW-1:0]         mem_rdata,
   output logic                  zflag,
   output logic [LANES-1:0]      lane_ovf,
   input  logic [VRW-1:0]        dbg_sel,
   output logic [LANES*DW-1:0]   dbg_data
);

   localparam int VW = LANES * DW;
   localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);
   localparam logic [IW-1:0] IDX_ZERO = '0;
`ifdef VECTOR_ENGINE_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   state_e              state_r;
   op_e                 op_r;
   logic [VRW-1:0]      vd_r;
   logic [VRW-1:0]      vs_r;
   logic [AW-1:0]       base_r;
   logic [IW-1:0]       idx_r;
   logic [DW-1:0]       temp_r [LANES];
   logic [VW-1:0]       opa_r;
   logic [VW-1:0]       opb_r;

   logic [IW-1:0]       idx_next_s;
   logic [VRW-1:0]      rd_a_addr_s;
   logic [VW-1:0]       rd_a_data_s;
   logic [VW-1:0]       rd_b_data_s;
   logic [DW-1:0]       rd_a_lane_s [LANES];
   logic [VW-1:0]       temp_vec_s;
   logic [VW-1:0]       sum_vec_s;
   logic [VW-1:0]       wb_data_s;
   logic [LANES-1:0]    carry_s;
   logic                sat_sel_s;
   logic                wb_we_s;

   assign idx_next_s = idx_r + IW'(1'b1);
   assign sat_sel_s  = SAT_EN && (op_r == OP_VADDS);
   assign wb_we_s    = (state_r == ST_WB);

   // Lane packing/unpacking and the per-lane adders; lane i's carry lands at the same
   // relative position as its data (lane 0 in the MSB).
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam int LSB = lane_lsb(LANES, DW, i);
      logic [DW:0] lane_sum_s;
      assign temp_vec_s[LSB +: DW] = temp_r[i];
      assign rd_a_lane_s[i]        = rd_a_data_s[LSB +: DW];
      assign lane_sum_s            = {1'b0, opa_r[LSB +: DW]} + {1'b0, opb_r[LSB +: DW]};
      assign carry_s[LANES-1-i]    = lane_sum_s[DW];
      assign sum_vec_s[LSB +: DW]  = (sat_sel_s && lane_sum_s[DW]) ? {DW{1'b1}} : lane_sum_s[DW-1:0];
   end

   // Read-port A follows the live vd input in IDLE so the first store lane is ready on accept
   always_comb begin
      rd_a_addr_s = vd_r;
      wb_data_s   = sum_vec_s;
      if (state_r == ST_IDLE) begin
         rd_a_addr_s = vd;
      end else begin
         rd_a_addr_s = vd_r;
      end
      if (op_r == OP_VLOAD) begin
         wb_data_s = temp_vec_s;
      end else begin
         wb_data_s = sum_vec_s;
      end
   end

   vector_regfile #(
      .LANES (LANES),
      .DW    (DW),
      .NVREG (NVREG),
      .VRW   (VRW)
   ) u_regfile (
      .clock    (clock),
      .reset    (reset),
      .we       (wb_we_s),
      .waddr    (vd_r),
      .wdata    (wb_data_s),
      .ra_addr  (rd_a_addr_s),
      .ra_data  (rd_a_data_s),
      .rb_addr  (vs_r),
      .rb_data  (rd_b_data_s),
      .dbg_sel  (dbg_sel),
      .dbg_data (dbg_data)
   );

   // Control FSM with registered status and memory-port outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         op_r      <= OP_VLOAD;
         vd_r      <= '0;
         vs_r      <= '0;
         base_r    <= '0;
         idx_r     <= '0;
         opa_r     <= '0;
         opb_r     <= '0;
         for (int i = 0; i < LANES; i++) begin
            temp_r[i] <= '0;
         end
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         zflag     <= 1'b0;
         lane_ovf  <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  op_r   <= op_e'(op);
                  vd_r   <= vd;
                  vs_r   <= vs;
                  base_r <= base;
                  idx_r  <= '0;
                  busy   <= 1'b1;
                  case (op)
                     OP_VLOAD: begin
                        state_r  <= ST_LOAD;
                        mem_re   <= 1'b1;
                        mem_addr <= base;
                     end
                     OP_VSTORE: begin
                        state_r   <= ST_STORE;
                        mem_we    <= 1'b1;
                        mem_addr  <= base;
                        mem_wdata <= rd_a_lane_s[IDX_ZERO];
                     end
                     OP_VADD: begin
                        state_r <= ST_ADD;
                     end
                     default: begin
                        state_r <= SAT_EN ? ST_ADD : ST_DONE;
                     end
                  endcase
               end
            end
            ST_LOAD: begin
               // Read data trails the address by one cycle, so lane idx-1 arrives now
               if (idx_r != IDX_ZERO) begin
                  temp_r[idx_r - IW'(1'b1)] <= mem_rdata;
               end
               if (idx_r == LAST_IDX) begin
                  state_r  <= ST_LWAIT;
                  mem_re   <= 1'b0;
                  mem_addr <= '0;
               end else begin
                  idx_r    <= idx_next_s;
                  mem_addr <= base_r + AW'(idx_next_s);
               end
            end
            ST_LWAIT: begin
               temp_r[LAST_IDX] <= mem_rdata;
               state_r          <= ST_WB;
            end
            ST_STORE: begin
               if (idx_r == LAST_IDX) begin
                  state_r   <= ST_DONE;
                  mem_we    <= 1'b0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
               end else begin
                  idx_r     <= idx_next_s;
                  mem_addr  <= base_r + AW'(idx_next_s);
                  mem_wdata <= rd_a_lane_s[idx_next_s];
               end
            end
            ST_ADD: begin
               opa_r   <= rd_a_data_s;
               opb_r   <= rd_b_data_s;
               state_r <= ST_WB;
            end
            ST_WB: begin
               zflag <= (wb_data_s == '0);
               if (op_r != OP_VLOAD) begin
                  lane_ovf <= carry_s;
               end
               state_r <= ST_DONE;
            end
            ST_DONE: begin
               done    <= 1'b1;
               err     <= (op_r == OP_VADDS) && !SAT_EN;
               busy    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               busy    <= 1'b0;
               mem_re  <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vector_engine.sv
// Scoreboard bench for vector_engine: expected memory writes and completions are queued at issue
// time and a monitor compares them against what the DUT presents.
module tb_vector_engine;

   logic        clock, reset, start;
   logic [1:0]  op, vd, vs, dbg_sel;
   logic [7:0]  base;
   logic        busy, done, err, mem_re, mem_we, zflag;
   logic [7:0]  mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  lane_ovf;
   logic [31:0] dbg_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int accept_cyc = 0;
   int done_cnt = 0;
   int re_cnt = 0;

   typedef struct {
      logic        is_wr;
      logic [7:0]  addr;
      logic [7:0]  data;
      logic        err;
      int          lat;
      logic [31:0] vreg;
      logic        z;
      logic [3:0]  ovf;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   logic [7:0] mem [256];

   vector_engine dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .vd        (vd),
      .vs        (vs),
      .base      (base),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .zflag     (zflag),
      .lane_ovf  (lane_ovf),
      .dbg_sel   (dbg_sel),
      .dbg_data  (dbg_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Synchronous memory model, preloaded while reset is held low
   always @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
         mem[8'h10] <= 8'h11; mem[8'h11] <= 8'h22; mem[8'h12] <= 8'h33; mem[8'h13] <= 8'h44;
         mem[8'h30] <= 8'hF0; mem[8'h31] <= 8'h01; mem[8'h32] <= 8'h02; mem[8'h33] <= 8'h03;
         mem[8'h40] <= 8'h20; mem[8'h41] <= 8'hFF; mem[8'h42] <= 8'h01; mem[8'h43] <= 8'h01;
         mem_rdata <= 8'h00;
      end else begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         if (mem_re) mem_rdata <= mem[mem_addr];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT writes memory or signals done
   always @(negedge clock) begin
      if (reset) begin
         if (mem_re) re_cnt++;
         if (mem_re || mem_we) chk("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
         if (mem_we) begin
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_write: addr %h data %h with empty scoreboard", mem_addr, mem_wdata);
            end else begin
               m_e = sb.pop_front();
               chk("wr_order", 32'(m_e.is_wr), 32'd1);
               chk("wr_addr", 32'(mem_addr), 32'(m_e.addr));
               chk("wr_data", 32'(mem_wdata), 32'(m_e.data));
            end
         end
         if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_done: err %b with empty scoreboard", err);
            end else begin
               m_e = sb.pop_front();
               chk("done_order", 32'(m_e.is_wr), 32'd0);
               chk("done_err", 32'(err), 32'(m_e.err));
               chk("done_latency", 32'(cyc - accept_cyc), 32'(m_e.lat));
               chk("vreg", dbg_data, m_e.vreg);
               chk("zflag", 32'(zflag), 32'(m_e.z));
               chk("lane_ovf", 32'(lane_ovf), 32'(m_e.ovf));
            end
         end
      end
   end

   task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
      exp_t e;
      e.is_wr = 1'b1; e.addr = a; e.data = d; e.err = 1'b0;
      e.lat = 0; e.vreg = 32'h0; e.z = 1'b0; e.ovf = 4'h0;
      sb.push_back(e);
   endtask

   task automatic push_done(input logic e_err, input int lat, input logic [31:0] v,
                            input logic z, input logic [3:0] ovf);
      exp_t e;
      e.is_wr = 1'b0; e.addr = 8'h00; e.data = 8'h00; e.err = e_err;
      e.lat = lat; e.vreg = v; e.z = z; e.ovf = ovf;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [1:0] o, input logic [1:0] d, input logic [1:0] s,
                        input logic [7:0] b);
      @(negedge clock);
      op = o; vd = d; vs = s; base = b; dbg_sel = d; start = 1'b1;
      @(posedge clock);
      #1;
      accept_cyc = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n0;
      int k;
      n0 = done_cnt;
      k = 0;
      while (done_cnt == n0 && k < 40) begin
         @(posedge clock);
         k++;
      end
      if (done_cnt == n0) begin
         checks++; failures++;
         $display("FAIL %s_timeout: no done within %0d cycles", name, k);
      end
   endtask

   logic [3:0] ovf_after_op11;
   int re0;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; start = 1'b0; op = 2'b00; vd = 2'd0; vs = 2'd0; base = 8'h00; dbg_sel = 2'd0;
      repeat (3) @(negedge clock);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_mem_re", 32'(mem_re), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_zflag", 32'(zflag), 32'd0);
      chk("rst_lane_ovf", 32'(lane_ovf), 32'd0);
      chk("rst_vrf0", dbg_data, 32'h0);
      reset = 1'b1;

      push_done(1'b0, 7, 32'h11223344, 1'b0, 4'b0000);
      issue(2'b00, 2'd1, 2'd0, 8'h10); wait_done("vload_v1");

      re0 = re_cnt;
      push_wr(8'hFE, 8'h11); push_wr(8'hFF, 8'h22); push_wr(8'h00, 8'h33); push_wr(8'h01, 8'h44);
      push_done(1'b0, 5, 32'h11223344, 1'b0, 4'b0000);
      issue(2'b01, 2'd1, 2'd0, 8'hFE); wait_done("vstore_wrap");
      chk("store_no_re", 32'(re_cnt - re0), 32'd0);

      push_done(1'b0, 7, 32'h22334400, 1'b0, 4'b0000);
      issue(2'b00, 2'd0, 2'd0, 8'hFF); wait_done("vload_wrap");

      push_done(1'b0, 7, 32'hF0010203, 1'b0, 4'b0000);
      issue(2'b00, 2'd1, 2'd0, 8'h30); wait_done("vload_v1b");
      push_done(1'b0, 7, 32'h20FF0101, 1'b0, 4'b0000);
      issue(2'b00, 2'd2, 2'd0, 8'h40); wait_done("vload_v2");

      // Zero vector load, with a start pulse while busy that must be dropped
      push_done(1'b0, 7, 32'h00000000, 1'b1, 4'b0000);
      issue(2'b00, 2'd3, 2'd0, 8'h20);
      @(negedge clock);
      op = 2'b10; vd = 2'd1; vs = 2'd2; start = 1'b1;
      repeat (2) @(negedge clock);
      start = 1'b0;
      wait_done("vload_zero");
      repeat (5) @(posedge clock);
      #1;
      chk("busy_start_ignored", 32'(busy), 32'd0);

`ifdef VECTOR_ENGINE_SAT_EN
      ovf_after_op11 = 4'b1100;
      push_done(1'b0, 3, 32'hFFFF0304, 1'b0, 4'b1100);
`else
      ovf_after_op11 = 4'b0000;
      push_done(1'b1, 1, 32'hF0010203, 1'b1, 4'b0000);
`endif
      issue(2'b11, 2'd1, 2'd2, 8'h00); wait_done("op11");

      push_done(1'b0, 7, 32'hF0010203, 1'b0, ovf_after_op11);
      issue(2'b00, 2'd1, 2'd0, 8'h30); wait_done("vload_v1c");

      push_done(1'b0, 3, 32'h10000304, 1'b0, 4'b1100);
      issue(2'b10, 2'd1, 2'd2, 8'h00); wait_done("vadd");
      push_done(1'b0, 3, 32'h40FE0202, 1'b0, 4'b0100);
      issue(2'b10, 2'd2, 2'd2, 8'h00); wait_done("vadd_double");
      push_done(1'b0, 3, 32'h00000000, 1'b1, 4'b0000);
      issue(2'b10, 2'd3, 2'd3, 8'h00); wait_done("vadd_zero");

      // Reset in the middle of a load (lane index 2)
      issue(2'b00, 2'd1, 2'd0, 8'h10);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_mem_re", 32'(mem_re), 32'd0);
      chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
      chk("midrst_zflag", 32'(zflag), 32'd0);
      chk("midrst_lane_ovf", 32'(lane_ovf), 32'd0);
      for (int r = 0; r < 4; r++) begin
         dbg_sel = 2'(r);
         #1;
         chk("midrst_vrf", dbg_data, 32'h0);
      end

      // First edge after reset release must accept start
      @(negedge clock);
      push_done(1'b0, 7, 32'h20FF0101, 1'b0, 4'b0000);
      reset = 1'b1;
      op = 2'b00; vd = 2'd2; vs = 2'd0; base = 8'h40; dbg_sel = 2'd2; start = 1'b1;
      @(posedge clock);
      #1;
      accept_cyc = cyc;
      start = 1'b0;
      chk("start_after_reset", 32'(busy), 32'd1);
      wait_done("vload_after_reset");

      repeat (3) @(posedge clock);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
